// File: rtl/mem_sram_ctrl.sv
// Memory-stage responder: each 32-bit load/store becomes two 16-bit accesses
// on an asynchronous SRAM, low halfword first. The pipeline is frozen while ready is low.
module mem_sram_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_CYCLES = 2,
    parameter int          ADDR_W      = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [31:0]       address,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    input  logic [15:0]       sram_dq_in,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                op_wr_q, op_wr_d;
    logic [ADDR_W-2:0]   base_q, base_d;
    logic [15:0]         whi_q, whi_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         dq_out_q, dq_out_d;
    logic                dq_oe_q, dq_oe_d;
    logic                ce_n_q, ce_n_d;
    logic                oe_n_q, oe_n_d;
    logic                we_n_q, we_n_d;

    logic        req;
    logic        cnt_last;
    logic [31:0] off;
    logic        unused_off_bits;

    assign req      = rd_en | wr_en;
    assign cnt_last = (cnt_q == CNT_LAST);
    // Byte offset from the SRAM window; the word index is off[ADDR_W:2] and everything else aliases.
    assign off      = address - BASE_ADDR;
    assign unused_off_bits = ^{off[31:ADDR_W+1], off[1:0]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_wr_d  = op_wr_q;
        base_d   = base_q;
        whi_d    = whi_q;
        rdata_d  = rdata_q;
        addr_d   = addr_q;
        dq_out_d = dq_out_q;
        dq_oe_d  = dq_oe_q;
        ce_n_d   = ce_n_q;
        oe_n_d   = oe_n_q;
        we_n_d   = we_n_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    // Strobes for the low half are set on the same edge that latches the request.
                    state_d = LO;
                    cnt_d   = 4'd0;
                    op_wr_d = wr_en;
                    base_d  = off[ADDR_W:2];
                    whi_d   = wdata[31:16];
                    addr_d  = {off[ADDR_W:2], 1'b0};
                    ce_n_d  = 1'b0;
                    oe_n_d  = wr_en;
                    we_n_d  = ~wr_en;
                    dq_oe_d = wr_en;
                    if (wr_en) begin
                        dq_out_d = wdata[15:0];
                    end
                end
            end
            LO: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_last) begin
                    state_d = HI;
                    cnt_d   = 4'd0;
                    addr_d  = {base_q, 1'b1};
                    if (op_wr_q) begin
                        dq_out_d = whi_q;
                    end else begin
                        rdata_d[15:0] = sram_dq_in;
                    end
                end
            end
            HI: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_last) begin
                    state_d = DONE;
                    cnt_d   = 4'd0;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    dq_oe_d = 1'b0;
                    if (!op_wr_q) begin
                        rdata_d[31:16] = sram_dq_in;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            op_wr_q  <= 1'b0;
            base_q   <= '0;
            whi_q    <= 16'd0;
            rdata_q  <= 32'd0;
            addr_q   <= '0;
            dq_out_q <= 16'd0;
            dq_oe_q  <= 1'b0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_wr_q  <= op_wr_d;
            base_q   <= base_d;
            whi_q    <= whi_d;
            rdata_q  <= rdata_d;
            addr_q   <= addr_d;
            dq_out_q <= dq_out_d;
            dq_oe_q  <= dq_oe_d;
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
        end
    end

    // A request in DONE belongs to the next instruction, so only IDLE looks at req.
    assign ready       = ((state_q == IDLE) && !req) || (state_q == DONE);
    assign rdata       = rdata_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl: default instance plus a WAIT_CYCLES=1 instance,
// each attached to a small behavioural SRAM; per-cycle expectations come from a queue.
module tb_mem_sram_ctrl;

    logic clk;
    logic rst;

    logic        rd0, wr0;
    logic [31:0] a0, wd0, rdata0;
    logic        ready0;
    logic [17:0] saddr0;
    logic [15:0] dqo0, dqi0;
    logic        dqoe0, ce0, oe0, we0;

    logic        rd1, wr1;
    logic [31:0] a1, wd1, rdata1;
    logic        ready1;
    logic [17:0] saddr1;
    logic [15:0] dqo1, dqi1;
    logic        dqoe1, ce1, oe1, we1;

    logic [15:0] mem0 [0:255] = '{default: 16'h0000};
    logic [15:0] mem1 [0:255] = '{default: 16'h0000};

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rdy;
        logic        ce_n;
        logic        oe_n;
        logic        we_n;
        logic        dq_oe;
        logic        chk_a;
        logic [17:0] a;
        logic        chk_d;
        logic [15:0] d;
        logic        chk_r;
        logic [31:0] r;
    } exp_t;

    exp_t sbq[$];

    mem_sram_ctrl u_dut0 (
        .clk(clk), .rst(rst), .rd_en(rd0), .wr_en(wr0), .address(a0), .wdata(wd0),
        .rdata(rdata0), .ready(ready0), .sram_addr(saddr0), .sram_dq_out(dqo0),
        .sram_dq_in(dqi0), .sram_dq_oe(dqoe0), .sram_ce_n(ce0), .sram_oe_n(oe0),
        .sram_we_n(we0)
    );

    mem_sram_ctrl #(.WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(wr1), .address(a1), .wdata(wd1),
        .rdata(rdata1), .ready(ready1), .sram_addr(saddr1), .sram_dq_out(dqo1),
        .sram_dq_in(dqi1), .sram_dq_oe(dqoe1), .sram_ce_n(ce1), .sram_oe_n(oe1),
        .sram_we_n(we1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dqi0 = (!ce0 && !oe0) ? mem0[saddr0[7:0]] : 16'h0000;
    assign dqi1 = (!ce1 && !oe1) ? mem1[saddr1[7:0]] : 16'h0000;

    always @(posedge clk) begin
        if (!ce0 && !we0) mem0[saddr0[7:0]] <= dqo0;
        if (!ce1 && !we1) mem1[saddr1[7:0]] <= dqo1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Queue the per-cycle expectations of one access, then compare as the DUT runs it.
    task automatic run_access(input int sel, input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [17:0] hb, input logic [31:0] er);
        int   w;
        exp_t e;
        w = (sel == 1) ? 1 : 2;
        for (int k = 0; k <= 2 * w + 1; k++) begin
            e = '{rdy: 1'b0, ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, dq_oe: 1'b0,
                  chk_a: 1'b0, a: 18'd0, chk_d: 1'b0, d: 16'd0, chk_r: 1'b0, r: 32'd0};
            if (k >= 1 && k <= 2 * w) begin
                e.ce_n  = 1'b0;
                e.oe_n  = wr;
                e.we_n  = ~wr;
                e.dq_oe = wr;
                e.chk_a = 1'b1;
                e.a     = (k <= w) ? hb : hb + 18'd1;
                e.chk_d = wr;
                e.d     = (k <= w) ? wd[15:0] : wd[31:16];
            end
            if (k == 2 * w + 1) begin
                e.rdy   = 1'b1;
                e.chk_r = 1'b1;
                e.r     = er;
            end
            sbq.push_back(e);
        end
        if (sel == 1) begin
            rd1 = rd; wr1 = wr; a1 = addr; wd1 = wd;
        end else begin
            rd0 = rd; wr0 = wr; a0 = addr; wd0 = wd;
        end
        for (int k = 0; k <= 2 * w + 1; k++) begin
            @(negedge clk);
            e = sbq.pop_front();
            if (sel == 1) begin
                check($sformatf("w1_ready[%0d]", k), 32'(ready1), 32'(e.rdy));
                check($sformatf("w1_ce_n[%0d]", k), 32'(ce1), 32'(e.ce_n));
                check($sformatf("w1_oe_n[%0d]", k), 32'(oe1), 32'(e.oe_n));
                check($sformatf("w1_we_n[%0d]", k), 32'(we1), 32'(e.we_n));
                check($sformatf("w1_dq_oe[%0d]", k), 32'(dqoe1), 32'(e.dq_oe));
                if (e.chk_a) check($sformatf("w1_addr[%0d]", k), 32'(saddr1), 32'(e.a));
                if (e.chk_d) check($sformatf("w1_dq[%0d]", k), 32'(dqo1), 32'(e.d));
                if (e.chk_r) check("w1_rdata", rdata1, e.r);
            end else begin
                check($sformatf("ready[%0d]", k), 32'(ready0), 32'(e.rdy));
                check($sformatf("ce_n[%0d]", k), 32'(ce0), 32'(e.ce_n));
                check($sformatf("oe_n[%0d]", k), 32'(oe0), 32'(e.oe_n));
                check($sformatf("we_n[%0d]", k), 32'(we0), 32'(e.we_n));
                check($sformatf("dq_oe[%0d]", k), 32'(dqoe0), 32'(e.dq_oe));
                if (e.chk_a) check($sformatf("addr[%0d]", k), 32'(saddr0), 32'(e.a));
                if (e.chk_d) check($sformatf("dq[%0d]", k), 32'(dqo0), 32'(e.d));
                if (e.chk_r) check("rdata", rdata0, e.r);
            end
            @(posedge clk);
            #1;
        end
        if (sel == 1) begin
            rd1 = 1'b0; wr1 = 1'b0;
        end else begin
            rd0 = 1'b0; wr0 = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b0;
        rd0 = 1'b1; wr0 = 1'b0; a0 = 32'd0; wd0 = 32'd0;
        rd1 = 1'b0; wr1 = 1'b0; a1 = 32'd0; wd1 = 32'd0;

        // Reset held with a pending load: nothing may start.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ce_n", 32'(ce0), 32'd1);
        check("rst_we_n", 32'(we0), 32'd1);
        check("rst_oe_n", 32'(oe0), 32'd1);
        check("rst_dq_oe", 32'(dqoe0), 32'd0);
        check("rst_rdata", rdata0, 32'd0);
        check("rst_addr", 32'(saddr0), 32'd0);
        rd0 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("idle_ready", 32'(ready0), 32'd1);
        check("idle_ce_n", 32'(ce0), 32'd1);

        // Store then load, back to back, then a second pair.
        run_access(0, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 18'd4, 32'h0);
        run_access(0, 1'b1, 1'b0, 32'd1032, 32'h0,       18'd4, 32'hDEADBEEF);
        check("mem_lo4", 32'(mem0[4]), 32'h0000BEEF);
        check("mem_hi5", 32'(mem0[5]), 32'h0000DEAD);
        run_access(0, 1'b0, 1'b1, 32'd1040, 32'h12345678, 18'd8, 32'hDEADBEEF);
        run_access(0, 1'b1, 1'b0, 32'd1040, 32'h0,        18'd8, 32'h12345678);

        // Both enables set: a write, rdata untouched.
        run_access(0, 1'b1, 1'b1, 32'd1048, 32'hCAFEF00D, 18'd12, 32'h12345678);
        run_access(0, 1'b1, 1'b0, 32'd1048, 32'h0,        18'd12, 32'hCAFEF00D);

        // Single-cycle halfwords and an unaligned byte address.
        run_access(1, 1'b0, 1'b1, 32'd1038, 32'hA5A55A5A, 18'd6, 32'h0);
        run_access(1, 1'b1, 1'b0, 32'd1038, 32'h0,        18'd6, 32'hA5A55A5A);
        check("w1_mem6", 32'(mem1[6]), 32'h00005A5A);
        check("w1_mem7", 32'(mem1[7]), 32'h0000A5A5);

        // Reset in the first HI cycle of a write.
        wr0 = 1'b1; a0 = 32'd1056; wd0 = 32'h11112222;
        repeat (3) @(posedge clk);
        #1;
        check("hi_we_n_before", 32'(we0), 32'd0);
        check("hi_addr_before", 32'(saddr0), 32'd17);
        rst = 1'b0;
        #1;
        check("abort_ce_n", 32'(ce0), 32'd1);
        check("abort_we_n", 32'(we0), 32'd1);
        check("abort_oe_n", 32'(oe0), 32'd1);
        check("abort_dq_oe", 32'(dqoe0), 32'd0);
        wr0 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort_ready", 32'(ready0), 32'd1);
        check("abort_rdata", rdata0, 32'd0);
        check("abort_mem_lo", 32'(mem0[16]), 32'h00002222);
        check("abort_mem_hi", 32'(mem0[17]), 32'h00000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_sram_ctrl.md
Name: mem_sram_ctrl

Overview:
- Memory-stage responder for the pipeline. It consumes the memory request carried out of the execute-stage register: read enable, write enable, ALU result used as the address, and Rm value used as store data.
- It performs each 32-bit access as two 16-bit halfword cycles on an external asynchronous SRAM.
- It drives `ready` low while busy. The top level inverts `ready` into the pipeline-wide freeze.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM halfword 0.
- WAIT_CYCLES, 2: clock cycles held per halfword access; legal range 1..15.
- ADDR_W, 18: SRAM halfword address width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- rd_en  in  1  load request; held stable while `ready`=0.
- wr_en  in  1  store request; held stable while `ready`=0.
- address  in  32  byte address (ALU result).
- wdata  in  32  store data (Val_RM).
- rdata  out  32  load result; registered.
- ready  out  1  1 means idle or access complete; 0 means pipeline must freeze.
- sram_addr  out  ADDR_W  halfword address.
- sram_dq_out  out  16  write data to SRAM.
- sram_dq_in  in  16  read data from SRAM.
- sram_dq_oe  out  1  1 means the top level drives the bidirectional DQ pad with sram_dq_out.
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes. UB_N/LB_N are tied low at top level.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, rdata=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0.
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1.
  - An access in flight is abandoned with no retry. The SRAM strobes deassert immediately.
- Request decode:
  - req = rd_en | wr_en.
  - When both enables are 1, the access is a write; rd_en is ignored.
- Address map:
  - off = address - BASE_ADDR, 32-bit wrap-around subtraction.
  - Low half uses halfword address {off[ADDR_W:2], 0}; high half uses {off[ADDR_W:2], 1}.
  - off[1:0] is ignored. Bits above ADDR_W are ignored, so addresses alias modulo 2^(ADDR_W+1) bytes.
- States: IDLE, LO, HI, DONE.
  - IDLE:
    - If req=1: latch op (write/read), the halfword base, and wdata into internal registers; go to LO with counter=0.
    - Otherwise stay in IDLE.
  - LO:
    - Access the low halfword. counter increments each cycle.
    - When counter = WAIT_CYCLES-1: go to HI with counter=0. On a read, capture sram_dq_in into rdata[15:0] on that same edge.
  - HI:
    - Access the high halfword.
    - When counter = WAIT_CYCLES-1: go to DONE. On a read, capture sram_dq_in into rdata[31:16] on that edge.
  - DONE: one cycle, then unconditionally go to IDLE.
- ready (combinational) = (state==IDLE & ~req) | (state==DONE).
  - `ready` drops in the same cycle a request appears.
  - Freeze length per access is 1 + 2*WAIT_CYCLES cycles (5 at default).
  - In DONE the pipeline advances on the next edge. The request seen in the following IDLE cycle belongs to the next instruction, so back-to-back memory instructions each take a full access.
- SRAM strobes (registered outputs, updated on the edge entering each state):
  - In LO/HI: sram_ce_n=0.
    - Read: sram_oe_n=0, sram_we_n=1, sram_dq_oe=0.
    - Write: sram_we_n=0, sram_oe_n=1, sram_dq_oe=1; sram_dq_out = latched wdata[15:0] in LO and wdata[31:16] in HI.
  - In IDLE/DONE: all strobes are 1 and sram_dq_oe=0.
  - sram_addr holds its last value outside an access.
- rdata:
  - Changes only on read captures and holds until the next read.
  - A write never changes rdata.
  - In DONE after a read, rdata holds the full 32-bit word.
- Request dropped mid-access (protocol violation): the access still completes. `ready` follows the equation above.

Test Plan:
- Reset: hold rst=0 with rd_en=1 → sram_ce_n=1, sram_we_n=1, sram_oe_n=1, rdata=0, state stays IDLE. Release rst with rd_en=wr_en=0 → ready=1.
- Write: wr_en=1, address=1024+8, wdata=0xDEADBEEF at default params →
  - ready=0 for exactly 5 cycles.
  - sram_addr=4 with dq_out=0xBEEF and we_n=0 for 2 cycles.
  - then sram_addr=5 with dq_out=0xDEAD for 2 cycles.
  - ready=1 in cycle 6.
- Read back: rd_en=1 at the same address, SRAM model returning the stored halfwords → rdata=0xDEADBEEF in the DONE cycle, sram_oe_n=0 during both halves, sram_dq_oe=0 throughout.
- Back-to-back and priority:
  - Store then load on consecutive instructions, each with freeze honoured → two separate 5-cycle busy windows separated by one ready=1 DONE cycle.
  - rd_en=wr_en=1 → a write occurs and rdata is unchanged.
- Wait and alignment: WAIT_CYCLES=1, address=1024+0x0E →
  - busy window is 3 cycles.
  - sram_addr is 6 then 7, because off[1:0] is ignored.
- Reset mid-access: assert rst during HI of a write → strobes go high asynchronously without waiting for clk. After release: IDLE, ready=1 (no request), and the high halfword is not written.
